// File: rtl/com_bus_arbiter.sv
// ----------------------------------------------------------------------------
// com_bus_arbiter
//
// Arbitrates the shared coherence bus among four cache wrappers. Snoop-side
// requests (flush / data supply) win over processor-side requests when the
// bus is idle. A snoop from a non-owner may nest inside an active processor
// grant. Processor grants rotate round-robin. Every release passes through a
// single TURN cycle with no grants before the next arbitration.
//
// Handshake: a requester holds its Com_Bus_Req_* bit high for as long as it
// wants the bus. A request sampled high on edge N yields a grant visible
// after edge N. A request sampled low on edge N removes its grant after
// edge N. A grant is always issued for at least one cycle once arbitrated,
// even if the request has already gone away.
//
// Optional feature (macro ARB_TIMEOUT_EN): watchdog on processor grants.
// Once a grant has been held for MAX_HOLD cycles, both grants are forced
// low, the round-robin pointer skips the owner and Arb_timeout is set
// until reset. Without the macro there is no counter and Arb_timeout = 0.
//
// Ports:
//   clk                    system clock, rising edge
//   rst_n                  asynchronous active-low reset
//   Com_Bus_Req_proc[3:0]  per-core processor-side request
//   Com_Bus_Req_snoop[3:0] per-core snoop-side request
//   Invalidation_done[3:0] per-core invalidate acknowledgement
//   Invalidate             shared Invalidate line as seen on the bus
//   Com_Bus_Gnt_proc[3:0]  one-hot-or-zero processor grant
//   Com_Bus_Gnt_snoop[3:0] one-hot-or-zero snoop grant
//   All_Invalidation_done  all non-owner cores acknowledged the invalidate
//   Bus_owner[1:0]         processor grant holder, valid while Bus_busy
//   Bus_busy               a processor grant is active
//   Arb_timeout            sticky watchdog flag
// ----------------------------------------------------------------------------
module com_bus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int MAX_HOLD  = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Com_Bus_Req_proc,
   input  logic [3:0] Com_Bus_Req_snoop,
   input  logic [3:0] Invalidation_done,
   input  logic       Invalidate,
   output logic [3:0] Com_Bus_Gnt_proc,
   output logic [3:0] Com_Bus_Gnt_snoop,
   output logic       All_Invalidation_done,
   output logic [1:0] Bus_owner,
   output logic       Bus_busy,
   output logic       Arb_timeout
);

   if (NUM_CORES != 4) begin : g_bad_num_cores
      $error("com_bus_arbiter supports exactly 4 cores");
   end
   if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("com_bus_arbiter needs MAX_HOLD >= 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      PROC_GNT,
      SNOOP_GNT,
      NESTED_SNOOP,
      TURN
   } arb_state_t;

   arb_state_t state;
   logic [1:0] rr_ptr;

   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      one_hot = 4'b0001 << idx;
   endfunction

   function automatic logic [1:0] lowest_idx(input logic [3:0] req);
      lowest_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) lowest_idx = 2'(k);
      end
   endfunction

   // Scan offsets from far to near so the nearest requester at or after
   // ptr is the last one written.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   logic [3:0] owner_oh;
   logic [3:0] foreign_snoop;
   logic [1:0] snoop_any_idx;
   logic [1:0] snoop_foreign_idx;
   logic [1:0] proc_pick_idx;
   logic       owner_req;
   logic       snoop_held;
   logic       others_done;
   logic       timeout_force;
   logic       proc_release;

   assign owner_oh          = one_hot(Bus_owner);
   // Gnt_proc is zero outside a processor grant, so this is 0 when idle.
   assign owner_req         = |(Com_Bus_Req_proc & Com_Bus_Gnt_proc);
   assign snoop_held        = |(Com_Bus_Req_snoop & Com_Bus_Gnt_snoop);
   // The owner's own snoop request never nests inside its processor grant.
   assign foreign_snoop     = Com_Bus_Req_snoop & ~owner_oh;
   assign snoop_any_idx     = lowest_idx(Com_Bus_Req_snoop);
   assign snoop_foreign_idx = lowest_idx(foreign_snoop);
   assign proc_pick_idx     = rr_pick(Com_Bus_Req_proc, rr_ptr);
   assign others_done       = &(Invalidation_done | owner_oh);
   assign proc_release      = !owner_req || timeout_force;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   logic [CNT_W-1:0] hold_cnt;
   logic             hold_limit;
   logic             new_proc_grant;
   logic             timeout_q;

   assign new_proc_grant = (state == IDLE) && !(|Com_Bus_Req_snoop) && (|Com_Bus_Req_proc);
   assign hold_limit     = (hold_cnt == CNT_W'(MAX_HOLD - 1));
   // An owner that lets go on the limit cycle releases normally.
   assign timeout_force  = Bus_busy && hold_limit && owner_req;
   assign Arb_timeout    = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (new_proc_grant) begin
            hold_cnt <= '0;
         end else if (Bus_busy && !hold_limit) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
         if (timeout_force) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_force = 1'b0;
   assign Arb_timeout   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         rr_ptr                <= 2'd0;
         Com_Bus_Gnt_proc      <= 4'b0000;
         Com_Bus_Gnt_snoop     <= 4'b0000;
         All_Invalidation_done <= 1'b0;
         Bus_owner             <= 2'd0;
         Bus_busy              <= 1'b0;
      end else begin
         // Gated with "grant survives this edge" so the flag falls together
         // with Bus_busy and is never high while the bus is free.
         All_Invalidation_done <= Bus_busy && !proc_release && Invalidate && others_done;

         case (state)
            IDLE: begin
               if (|Com_Bus_Req_snoop) begin
                  Com_Bus_Gnt_snoop <= one_hot(snoop_any_idx);
                  state             <= SNOOP_GNT;
               end else if (|Com_Bus_Req_proc) begin
                  Com_Bus_Gnt_proc <= one_hot(proc_pick_idx);
                  Bus_owner        <= proc_pick_idx;
                  Bus_busy         <= 1'b1;
                  state            <= PROC_GNT;
               end
            end

            PROC_GNT: begin
               if (proc_release) begin
                  Com_Bus_Gnt_proc <= 4'b0000;
                  Bus_busy         <= 1'b0;
                  rr_ptr           <= Bus_owner + 2'd1;
                  state            <= TURN;
               end else if (|foreign_snoop) begin
                  Com_Bus_Gnt_snoop <= one_hot(snoop_foreign_idx);
                  state             <= NESTED_SNOOP;
               end
            end

            NESTED_SNOOP: begin
               if (proc_release) begin
                  Com_Bus_Gnt_proc <= 4'b0000;
                  Bus_busy         <= 1'b0;
                  rr_ptr           <= Bus_owner + 2'd1;
                  // A normal owner release leaves a live snoop grant running
                  // alone; a watchdog release tears both down.
                  if (snoop_held && !timeout_force) begin
                     state <= SNOOP_GNT;
                  end else begin
                     Com_Bus_Gnt_snoop <= 4'b0000;
                     state             <= TURN;
                  end
               end else if (!snoop_held) begin
                  Com_Bus_Gnt_snoop <= 4'b0000;
                  state             <= PROC_GNT;
               end
            end

            SNOOP_GNT: begin
               if (!snoop_held) begin
                  Com_Bus_Gnt_snoop <= 4'b0000;
                  state             <= TURN;
               end
            end

            TURN: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_com_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_com_bus_arbiter
//
// Directed scenarios followed by a randomized run. A grant-level reference
// model (who holds the processor grant, who holds the snoop grant, how many
// dead cycles remain before arbitration) predicts every output after every
// rising edge. Build with +define+ARB_TIMEOUT_EN to exercise the watchdog
// with MAX_HOLD = 8.
// ----------------------------------------------------------------------------
module tb_com_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int TB_MAX_HOLD = 8;
   localparam bit TO_EN       = 1'b1;
`else
   localparam int TB_MAX_HOLD = 64;
   localparam bit TO_EN       = 1'b0;
`endif
   localparam int EXP_CORE2_CYCLES = TO_EN ? 8 : 20;

   // ---------------- clock / reset / DUT ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req_p = 4'b0000;
   logic [3:0] req_s = 4'b0000;
   logic [3:0] inv_done = 4'b0000;
   logic       inv   = 1'b0;

   logic [3:0] Com_Bus_Gnt_proc;
   logic [3:0] Com_Bus_Gnt_snoop;
   logic       All_Invalidation_done;
   logic [1:0] Bus_owner;
   logic       Bus_busy;
   logic       Arb_timeout;

   always #5 clk = ~clk;

   com_bus_arbiter #(
      .NUM_CORES (4),
      .MAX_HOLD  (TB_MAX_HOLD)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .Com_Bus_Req_proc      (req_p),
      .Com_Bus_Req_snoop     (req_s),
      .Invalidation_done     (inv_done),
      .Invalidate            (inv),
      .Com_Bus_Gnt_proc      (Com_Bus_Gnt_proc),
      .Com_Bus_Gnt_snoop     (Com_Bus_Gnt_snoop),
      .All_Invalidation_done (All_Invalidation_done),
      .Bus_owner             (Bus_owner),
      .Bus_busy              (Bus_busy),
      .Arb_timeout           (Arb_timeout)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_p / m_s: core holding the processor / snoop grant, -1 when none.
   // m_cool: dead cycles still owed before arbitration may happen.
   int m_p, m_s, m_cool, m_rr, m_hold;
   bit m_to, m_inv;

   function automatic int first_set(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int rr_first(input logic [3:0] v, input int ptr);
      for (int off = 0; off < 4; off++) if (v[(ptr + off) % 4]) return (ptr + off) % 4;
      return -1;
   endfunction

   function automatic bit others_acked(input int owner, input logic [3:0] done);
      for (int i = 0; i < 4; i++) if (i != owner && !done[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_p = -1; m_s = -1; m_cool = 0; m_rr = 0; m_hold = 0; m_to = 1'b0; m_inv = 1'b0;
   endtask

   task automatic model_step();
      int np, ns, ncool;
      bit forced, p_rel;
      logic [3:0] foreign;
      np = m_p; ns = m_s; ncool = m_cool; forced = 1'b0; p_rel = 1'b0;
      if (m_p < 0 && m_s < 0) begin
         if (m_cool > 0) ncool = m_cool - 1;
         else if (req_s != 4'b0000) ns = first_set(req_s);
         else if (req_p != 4'b0000) begin
            np = rr_first(req_p, m_rr);
            m_hold = 0;
         end
      end else begin
         if (m_p >= 0) begin
            if (TO_EN && m_hold == TB_MAX_HOLD - 1 && req_p[m_p]) begin
               forced = 1'b1;
               m_to   = 1'b1;
            end
            if (!req_p[m_p] || forced) begin
               np    = -1;
               m_rr  = (m_p + 1) % 4;
               p_rel = 1'b1;
            end else begin
               m_hold++;
            end
         end
         if (forced) ns = -1;
         else if (m_s >= 0) begin
            if (!req_s[m_s]) ns = -1;
         end else if (!p_rel) begin
            foreign = req_s & ~(4'b0001 << m_p);
            if (foreign != 4'b0000) ns = first_set(foreign);
         end
         if (np < 0 && ns < 0) ncool = 1;
      end
      m_inv  = (m_p >= 0) && (np >= 0) && inv && others_acked(m_p, inv_done);
      m_p    = np;
      m_s    = ns;
      m_cool = ncool;
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] ep, es;
      ep = (m_p >= 0) ? 4'(1 << m_p) : 4'b0000;
      es = (m_s >= 0) ? 4'(1 << m_s) : 4'b0000;
      chk(tag, "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'(ep));
      chk(tag, "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'(es));
      chk(tag, "bus_busy",  8'(Bus_busy), 8'(m_p >= 0));
      chk(tag, "all_inv",   8'(All_Invalidation_done), 8'(m_inv));
      chk(tag, "timeout",   8'(Arb_timeout), 8'(m_to));
      if (m_p >= 0) chk(tag, "owner", 8'(Bus_owner), 8'(m_p));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      req_p = 4'b0000; req_s = 4'b0000; inv = 1'b0; inv_done = 4'b0000;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("reset", "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'h00);
      chk("reset", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h00);
      chk("reset", "busy",      8'(Bus_busy), 8'h00);
      chk("reset", "owner",     8'(Bus_owner), 8'h00);
      chk("reset", "all_inv",   8'(All_Invalidation_done), 8'h00);
      chk("reset", "timeout",   8'(Arb_timeout), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic [1:0] exp_q[$];
   int held, gap, grants_seen, core2_cycles;
   bit saw_core3;

   initial begin
      #1;
      do_reset();

      // Single request, release, TURN.
      tick("idle");
      req_p = 4'b0100;
      tick("tp1_grant");
      chk("tp1", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h04);
      chk("tp1", "owner",    8'(Bus_owner), 8'd2);
      chk("tp1", "busy",     8'(Bus_busy), 8'd1);
      tick("tp1_hold");
      tick("tp1_hold");
      req_p = 4'b0000;
      tick("tp1_drop");
      chk("tp1_drop", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h00);
      tick("tp1_turn");
      tick("tp1_idle");

      // Round-robin rotation with every core requesting.
      do_reset();
      req_p = 4'hF; held = 0; gap = 0; grants_seen = 0;
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         tick("rr");
         if (Bus_busy) begin
            if (held == 0) begin
               chk("rr_order", "owner", 8'(Bus_owner), 8'(exp_q.pop_front()));
               if (grants_seen > 0) chk("rr_gap", "idle_cycles", 8'(gap), 8'd2);
               grants_seen++;
               gap = 0;
            end
            held++;
            if (held == 3) req_p[Bus_owner] = 1'b0;
         end else begin
            held = 0;
            gap++;
            req_p = 4'hF;
         end
      end
      chk("rr_done", "remaining", 8'(exp_q.size()), 8'd0);

      // Snoop beats proc from IDLE; proc follows after release + TURN.
      do_reset();
      req_p = 4'b0001; req_s = 4'b0010;
      tick("tp3_snoop");
      chk("tp3", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h02);
      chk("tp3", "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'h00);
      tick("tp3_hold");
      req_s = 4'b0000;
      tick("tp3_drop");
      chk("tp3_drop", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h00);
      tick("tp3_turn");
      chk("tp3_turn", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h00);
      tick("tp3_proc");
      chk("tp3_proc", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h01);

      // Nested snoop from core 3 while core 0 owns; owner snoop ignored.
      req_s = 4'b1000;
      tick("tp4_nest");
      chk("tp4", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h08);
      chk("tp4", "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'h01);
      tick("tp4_hold");
      req_s = 4'b0000;
      tick("tp4_drop");
      chk("tp4_drop", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h00);
      chk("tp4_drop", "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'h01);
      req_s = 4'b0001;
      tick("tp4_own_snoop");
      tick("tp4_own_snoop");
      chk("tp4_own", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h00);
      req_s = 4'b0000;
      tick("tp4_end");

      // All_Invalidation_done with owner 1.
      do_reset();
      req_p = 4'b0010;
      tick("tp5_grant");
      inv = 1'b1; inv_done = 4'b1101;
      tick("tp5_all");
      chk("tp5_all", "all_inv", 8'(All_Invalidation_done), 8'd1);
      inv_done = 4'b1001;
      tick("tp5_missing");
      chk("tp5_missing", "all_inv", 8'(All_Invalidation_done), 8'd0);
      inv_done = 4'b1101;
      tick("tp5_again");
      inv = 1'b0;
      tick("tp5_inv_fall");
      chk("tp5_inv_fall", "all_inv", 8'(All_Invalidation_done), 8'd0);
      inv = 1'b1;
      tick("tp5_inv_rise");
      req_p = 4'b0000;
      tick("tp5_release");
      chk("tp5_release", "all_inv", 8'(All_Invalidation_done), 8'd0);
      inv = 1'b0; inv_done = 4'b0000;
      tick("tp5_turn");

      // Owner releases while its nested snoop is still active.
      do_reset();
      req_p = 4'b0001;
      tick("nest_grant");
      req_s = 4'b0100;
      tick("nest_snoop");
      req_p = 4'b0000;
      tick("nest_owner_drop");
      chk("nest_owner_drop", "gnt_proc",  8'(Com_Bus_Gnt_proc), 8'h00);
      chk("nest_owner_drop", "gnt_snoop", 8'(Com_Bus_Gnt_snoop), 8'h04);
      tick("nest_snoop_alone");
      req_s = 4'b0000;
      tick("nest_snoop_drop");
      tick("nest_turn");
      tick("nest_idle");

      // Request gone before its grant: one-cycle grant, then release.
      req_p = 4'b0010;
      tick("short_grant");
      chk("short", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h02);
      req_p = 4'b0000;
      tick("short_release");
      chk("short_release", "gnt_proc", 8'(Com_Bus_Gnt_proc), 8'h00);
      tick("short_turn");

      // Asynchronous reset in the middle of a grant.
      req_p = 4'b1000;
      tick("async_grant");
      do_reset();
      tick("after_async");

      // Watchdog: core 2 hogs the bus while core 3 waits.
      req_p = 4'b1100; core2_cycles = 0; saw_core3 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick("watchdog");
         if (Bus_busy && Bus_owner == 2'd2) core2_cycles++;
         if (Bus_busy && Bus_owner == 2'd3) saw_core3 = 1'b1;
      end
      chk("watchdog", "core2_cycles", 8'(core2_cycles), 8'(EXP_CORE2_CYCLES));
      chk("watchdog", "core3_granted", 8'(saw_core3), 8'(TO_EN));
      chk("watchdog", "arb_timeout", 8'(Arb_timeout), 8'(TO_EN));
      req_p = 4'b0000;
      tick("watchdog_end");
      tick("watchdog_end");

      // Randomized traffic, with one reset in the middle.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if (c == 400) do_reset();
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) req_p[b] = 1'($urandom_range(0, 1));
            if (req_s[b]) begin
               if ($urandom_range(0, 2) == 0) req_s[b] = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
               req_s[b] = 1'b1;
            end
         end
         inv      = 1'($urandom_range(0, 1));
         inv_done = 4'($urandom);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/com_bus_arbiter.md
Name: com_bus_arbiter

Overview:
- Arbitrates the shared coherence bus (Address_Com, Data_Bus_Com, BusRd, BusRdX, Invalidate) among the four cache_wrapper instances.
- Consumes each wrapper's Com_Bus_Req_proc / Com_Bus_Req_snoop and drives the matching Com_Bus_Gnt_proc / Com_Bus_Gnt_snoop.
- Aggregates per-core Invalidation_done into the All_Invalidation_done returned to the bus owner.
- Sits directly between the cache wrappers and the shared-bus and memory glue.

Parameters:
- NUM_CORES, 4, number of cache wrappers. The RTL supports only 4; the parameter exists for elaboration checks.
- MAX_HOLD, 64, watchdog limit in cycles for a single processor-side grant. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Com_Bus_Req_proc  input  4  per-core processor-side bus request; bit i is core i.
- Com_Bus_Req_snoop  input  4  per-core snoop-side request, used to flush or supply data.
- Invalidation_done  input  4  per-core acknowledgement that an Invalidate was applied.
- Invalidate  input  1  shared Invalidate line, as observed on the bus.
- Com_Bus_Gnt_proc  output  4  one-hot-or-zero processor grant.
- Com_Bus_Gnt_snoop  output  4  one-hot-or-zero snoop grant.
- All_Invalidation_done  output  1  every non-owner core has acknowledged the invalidation.
- Bus_owner  output  2  index of the current processor-grant holder; valid while Bus_busy = 1.
- Bus_busy  output  1  a processor grant is active.
- Arb_timeout  output  1  sticky watchdog flag. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Round-robin pointer rr_ptr = 0.
  - Hold counter = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, PROC_GNT, SNOOP_GNT, NESTED_SNOOP, TURN.
- IDLE:
  - If any snoop request is high, grant the lowest-index snoop requester; go to SNOOP_GNT. Snoop has priority over proc.
  - Else, if any proc request is high, grant the first requester at or after rr_ptr, cyclically; go to PROC_GNT. Set Bus_busy = 1 and Bus_owner = index.
- Latency: a request sampled high in cycle N gives a grant high in cycle N+1.
- PROC_GNT:
  - The grant holds while the owner's Com_Bus_Req_proc stays high.
  - If a snoop request from a non-owner core arrives, issue that snoop grant (lowest index) while keeping the proc grant; go to NESTED_SNOOP.
  - A snoop request from the owner itself is ignored.
  - When the owner drops its request in cycle N: the grant falls in N+1, rr_ptr = owner+1 mod 4, and the FSM goes to TURN.
- NESTED_SNOOP:
  - When the snoop requester drops its request, the snoop grant falls next cycle; return to PROC_GNT.
  - If the owner drops its proc request first, the proc grant releases as normal. The snoop grant persists until its request drops, then go to TURN.
- SNOOP_GNT: when the request drops, the grant falls next cycle; go to TURN.
- TURN: one idle cycle with no grants, then IDLE. The earliest new grant is N+3 after a request drop at N.
- Grant invariants:
  - At most one bit set in Com_Bus_Gnt_proc.
  - At most one bit set in Com_Bus_Gnt_snoop.
  - Proc and snoop grants never go to the same core.
- All_Invalidation_done:
  - Registered high when Bus_busy = 1, Invalidate = 1, and Invalidation_done is high for all cores other than Bus_owner.
  - Cleared the cycle after Invalidate falls or the proc grant drops.
  - Always 0 when Bus_busy = 0.
- A request that drops before its grant arrives: the grant is still issued for one cycle, then released through TURN. No grant is ever lost mid-handshake.
- Reset mid-grant: all grants drop immediately (asynchronously).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The hold counter increments each cycle in PROC_GNT and NESTED_SNOOP.
  - On reaching MAX_HOLD-1, both grants are forced low next cycle; go to TURN.
  - rr_ptr advances past the owner.
  - Arb_timeout is set and stays high until reset.
  - The counter clears on each new proc grant.
- When undefined: there is no counter, grants hold indefinitely, and Arb_timeout is tied 0.

Test Plan:
- Reset, then Req_proc = 4'b0100 at cycle 2 -> Gnt_proc = 4'b0100, Bus_owner = 2, Bus_busy = 1 at cycle 3. Drop req at 6 -> grant 0 at 7, idle at 8.
- Req_proc = 4'b1111 held continuously, each owner holding 3 cycles -> grant order 0, 1, 2, 3, 0, with one TURN cycle between grants.
- Req_proc = 4'b0001 and Req_snoop = 4'b0010 simultaneously from IDLE -> Gnt_snoop = 4'b0010 first. Gnt_proc = 4'b0001 only after the snoop release plus TURN.
- Core 0 owns the bus; core 3 raises Req_snoop -> Gnt_snoop = 4'b1000 next cycle while Gnt_proc = 4'b0001 stays high. Core 3 drops -> snoop grant clears and the proc grant is unchanged.
- Owner 1, Invalidate = 1, Invalidation_done = 4'b1101 -> All_Invalidation_done = 1 next cycle. With 4'b1001 -> stays 0.
- With ARB_TIMEOUT_EN and MAX_HOLD = 8, core 2 holds its request for 20 cycles -> grant drops after 8 cycles, Arb_timeout = 1, and the next pending requester (core 3) is granted.
